// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg: shared AHB transfer/response encodings and response-state enum for the AHB-to-APB bridge
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        RSP_OKAY,
        RSP_ERR1,
        RSP_ERR2
    } rsp_state_t;

    // IDLE and BUSY never start a transfer; NONSEQ and SEQ do
    function automatic logic is_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// ahb_addr_decode: combinational base/slot range check and one-hot slot select, shared with the APB controller
module ahb_addr_decode
    import ahb_apb_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                NUM_SLV   = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                SLOT_LOG2 = 26
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic               mapped,
    output logic [NUM_SLV-1:0] selx
);

    // upper bound is one bit wider than the address so a map ending at the top of memory cannot wrap
    localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE_ADDR} + ((ADDR_W+1)'(NUM_SLV) << SLOT_LOG2);

    logic [ADDR_W-1:0] slot;

    assign mapped = (addr >= BASE_ADDR) && ({1'b0, addr} < LIMIT);
    assign slot   = (addr - BASE_ADDR) >> SLOT_LOG2;

    // one-hot select of the slot the address falls in; all zeros outside the map
    always_comb begin
        selx = '0;
        for (int i = 0; i < NUM_SLV; i++)
            selx[i] = mapped && (slot == ADDR_W'(i));
    end

endmodule

// File: rtl/ahb_slave_if_mc.sv
// ahb_slave_if_mc: AHB slave front end with slot decode, stall-aware pipeline and response generation.
// Define AHB_SLV_ERR_RESP_EN to answer unmapped transfers with a two-cycle ERROR and count them in err_cnt.
module ahb_slave_if_mc
    import ahb_apb_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                NUM_SLV    = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                SLOT_LOG2  = 26,
    parameter int                PIPE_DEPTH = 2,
    parameter int                ERR_CNT_W  = 8
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic                 hwrite,
    input  logic                 hreadyin,
    input  logic [1:0]           htrans,
    input  logic [ADDR_W-1:0]    haddr,
    input  logic [DATA_W-1:0]    hwdata,
    input  logic [DATA_W-1:0]    prdata,
    input  logic                 bridge_ready,
    output logic                 valid,
    output logic [NUM_SLV-1:0]   temp_selx,
    output logic [ADDR_W-1:0]    haddr_1,
    output logic [ADDR_W-1:0]    haddr_n,
    output logic [DATA_W-1:0]    hwdata_1,
    output logic [DATA_W-1:0]    hwdata_n,
    output logic                 hwrite_1,
    output logic                 hwrite_n,
    output logic [DATA_W-1:0]    hrdata,
    output logic                 hreadyout,
    output logic [1:0]           hresp,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic mapped;

    logic [ADDR_W-1:0] addr_q  [PIPE_DEPTH];
    logic [DATA_W-1:0] data_q  [PIPE_DEPTH];
    logic              write_q [PIPE_DEPTH];

    ahb_addr_decode #(
        .ADDR_W    (ADDR_W),
        .NUM_SLV   (NUM_SLV),
        .BASE_ADDR (BASE_ADDR),
        .SLOT_LOG2 (SLOT_LOG2)
    ) u_decode (
        .addr   (haddr),
        .mapped (mapped),
        .selx   (temp_selx)
    );

    assign valid  = hreadyin && is_active(htrans) && mapped;
    assign hrdata = prdata;

    genvar k;
    generate
        for (k = 0; k < PIPE_DEPTH; k++) begin : g_pipe
            if (k == 0) begin : g_first
                // first stage captures the bus whenever the AHB side is not stalled
                always_ff @(posedge hclk) begin
                    if (hreset) begin
                        addr_q[k]  <= '0;
                        data_q[k]  <= '0;
                        write_q[k] <= 1'b0;
                    end else if (hreadyin) begin
                        addr_q[k]  <= haddr;
                        data_q[k]  <= hwdata;
                        write_q[k] <= hwrite;
                    end
                end
            end else begin : g_next
                // later stages shift from the previous stage in lockstep with the first
                always_ff @(posedge hclk) begin
                    if (hreset) begin
                        addr_q[k]  <= '0;
                        data_q[k]  <= '0;
                        write_q[k] <= 1'b0;
                    end else if (hreadyin) begin
                        addr_q[k]  <= addr_q[k-1];
                        data_q[k]  <= data_q[k-1];
                        write_q[k] <= write_q[k-1];
                    end
                end
            end
        end
    endgenerate

    assign haddr_1  = addr_q[0];
    assign haddr_n  = addr_q[PIPE_DEPTH-1];
    assign hwdata_1 = data_q[0];
    assign hwdata_n = data_q[PIPE_DEPTH-1];
    assign hwrite_1 = write_q[0];
    assign hwrite_n = write_q[PIPE_DEPTH-1];

`ifdef AHB_SLV_ERR_RESP_EN
    rsp_state_t state;
    logic       miss;

    assign miss = hreadyin && is_active(htrans) && !mapped;

    // ERR1 always advances to ERR2; otherwise a miss starts a new error, else back to OKAY
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state   <= RSP_OKAY;
            hresp   <= HRESP_OKAY;
            err_cnt <= '0;
        end else begin
            state   <= (state == RSP_ERR1) ? RSP_ERR2 : miss ? RSP_ERR1 : RSP_OKAY;
            hresp   <= ((state == RSP_ERR1) || miss) ? HRESP_ERROR : HRESP_OKAY;
            err_cnt <= (miss && !(&err_cnt)) ? err_cnt + ERR_CNT_W'(1) : err_cnt;
        end
    end

    assign hreadyout = (state == RSP_OKAY) ? bridge_ready : (state == RSP_ERR2);
`else
    assign hresp     = HRESP_OKAY;
    assign hreadyout = bridge_ready;
    assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_ahb_slave_if_mc.sv
// tb_ahb_slave_if_mc: scoreboard bench for ahb_slave_if_mc covering decode, pipeline, responses and err_cnt saturation
module tb_ahb_slave_if_mc;
    import ahb_apb_pkg::*;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int NUM_SLV    = 3;
    localparam int PIPE_DEPTH = 2;
    localparam int ERR_CNT_W  = 2;
`ifdef AHB_SLV_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 hreset;
    logic                 hwrite;
    logic                 hreadyin;
    logic [1:0]           htrans;
    logic [ADDR_W-1:0]    haddr;
    logic [DATA_W-1:0]    hwdata;
    logic [DATA_W-1:0]    prdata;
    logic                 bridge_ready;
    logic                 valid;
    logic [NUM_SLV-1:0]   temp_selx;
    logic [ADDR_W-1:0]    haddr_1, haddr_n;
    logic [DATA_W-1:0]    hwdata_1, hwdata_n;
    logic                 hwrite_1, hwrite_n;
    logic [DATA_W-1:0]    hrdata;
    logic                 hreadyout;
    logic [1:0]           hresp;
    logic [ERR_CNT_W-1:0] err_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [1:0] resp;
        logic       rdy;
    } rsp_t;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              w;
    } xfer_t;

    rsp_t  rq[$];
    xfer_t pq[$];
    xfer_t last_n;

    ahb_slave_if_mc #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .NUM_SLV    (NUM_SLV),
        .BASE_ADDR  (32'h8000_0000),
        .SLOT_LOG2  (26),
        .PIPE_DEPTH (PIPE_DEPTH),
        .ERR_CNT_W  (ERR_CNT_W)
    ) dut (
        .hclk         (clk),
        .hreset       (hreset),
        .hwrite       (hwrite),
        .hreadyin     (hreadyin),
        .htrans       (htrans),
        .haddr        (haddr),
        .hwdata       (hwdata),
        .prdata       (prdata),
        .bridge_ready (bridge_ready),
        .valid        (valid),
        .temp_selx    (temp_selx),
        .haddr_1      (haddr_1),
        .haddr_n      (haddr_n),
        .hwdata_1     (hwdata_1),
        .hwdata_n     (hwdata_n),
        .hwrite_1     (hwrite_1),
        .hwrite_n     (hwrite_n),
        .hrdata       (hrdata),
        .hreadyout    (hreadyout),
        .hresp        (hresp),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_rsp(input string tag);
        rsp_t e;
        if (rq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = rq.pop_front();
            chk({tag, "_hresp"}, 64'(hresp), 64'(e.resp));
            chk({tag, "_hreadyout"}, 64'(hreadyout), 64'(e.rdy));
        end
    endtask

    task automatic pipe_push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic w);
        xfer_t e;
        haddr    = a;
        hwdata   = d;
        hwrite   = w;
        hreadyin = 1'b1;
        htrans   = HTRANS_NONSEQ;
        pq.push_back('{a, d, w});
        tick();
        chk("pipe_haddr_1", 64'(haddr_1), 64'(a));
        chk("pipe_hwdata_1", 64'(hwdata_1), 64'(d));
        chk("pipe_hwrite_1", 64'(hwrite_1), 64'(w));
        if (pq.size() == PIPE_DEPTH) begin
            e = pq.pop_front();
            last_n = e;
            chk("pipe_haddr_n", 64'(haddr_n), 64'(e.a));
            chk("pipe_hwdata_n", 64'(hwdata_n), 64'(e.d));
            chk("pipe_hwrite_n", 64'(hwrite_n), 64'(e.w));
        end
    endtask

    task automatic miss_seq(input string tag, input logic br);
        bridge_ready = br;
        hreadyin     = 1'b1;
        htrans       = HTRANS_NONSEQ;
        haddr        = 32'h9000_0000;
        #1;
        chk({tag, "_valid"}, 64'(valid), 64'(0));
        chk({tag, "_rdy_pre"}, 64'(hreadyout), 64'(br));
        rq.push_back('{ERR_EN ? HRESP_ERROR : HRESP_OKAY, ERR_EN ? 1'b0 : br});
        rq.push_back('{ERR_EN ? HRESP_ERROR : HRESP_OKAY, ERR_EN ? 1'b1 : br});
        rq.push_back('{HRESP_OKAY, br});
        exp_cnt = ERR_EN ? ((exp_cnt == 3) ? 3 : exp_cnt + 1) : 0;
        tick();
        htrans = HTRANS_IDLE;
        #1;
        pop_rsp({tag, "_c1"});
        tick();
        pop_rsp({tag, "_c2"});
        tick();
        pop_rsp({tag, "_c3"});
        chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        hreset       = 1'b1;
        hwrite       = 1'b1;
        hreadyin     = 1'b1;
        htrans       = HTRANS_IDLE;
        haddr        = 32'h8000_1234;
        hwdata       = 32'h55;
        prdata       = 32'h0;
        bridge_ready = 1'b1;
        tick();
        tick();
        chk("rst_haddr_1", 64'(haddr_1), 64'(0));
        chk("rst_haddr_n", 64'(haddr_n), 64'(0));
        chk("rst_hwdata_1", 64'(hwdata_1), 64'(0));
        chk("rst_hwdata_n", 64'(hwdata_n), 64'(0));
        chk("rst_hwrite_1", 64'(hwrite_1), 64'(0));
        chk("rst_hwrite_n", 64'(hwrite_n), 64'(0));
        chk("rst_hreadyout", 64'(hreadyout), 64'(1));
        chk("rst_hresp", 64'(hresp), 64'(HRESP_OKAY));
        chk("rst_err_cnt", 64'(err_cnt), 64'(0));
        hreset = 1'b0;

        htrans = HTRANS_NONSEQ;
        haddr  = 32'h8400_0010;
        prdata = 32'hCAFE_F00D;
        #1;
        chk("dec_valid", 64'(valid), 64'(1));
        chk("dec_selx", 64'(temp_selx), 64'(3'b010));
        chk("dec_hrdata", 64'(hrdata), 64'(32'hCAFE_F00D));
        htrans = HTRANS_IDLE;
        #1;
        chk("dec_idle_valid", 64'(valid), 64'(0));
        chk("dec_idle_selx", 64'(temp_selx), 64'(3'b010));
        htrans = HTRANS_SEQ;
        haddr  = 32'h8BFF_FFFC;
        #1;
        chk("dec_top_valid", 64'(valid), 64'(1));
        chk("dec_top_selx", 64'(temp_selx), 64'(3'b100));
        hreadyin = 1'b0;
        #1;
        chk("dec_nordy_valid", 64'(valid), 64'(0));
        hreadyin = 1'b1;
        htrans   = HTRANS_IDLE;
        haddr    = 32'h8C00_0000;
        #1;
        chk("dec_above_selx", 64'(temp_selx), 64'(0));
        haddr = 32'h7FFF_FFFF;
        #1;
        chk("dec_below_selx", 64'(temp_selx), 64'(0));
        haddr = 32'h8000_0000;
        #1;
        chk("dec_base_selx", 64'(temp_selx), 64'(3'b001));

        pipe_push(32'h8000_0000, 32'h11, 1'b1);
        pipe_push(32'h8000_0004, 32'h22, 1'b1);
        pipe_push(32'h8000_0008, 32'h33, 1'b1);
        hreadyin = 1'b0;
        haddr    = 32'h8000_0100;
        hwdata   = 32'hFF;
        hwrite   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_haddr_n", 64'(haddr_n), 64'(last_n.a));
            chk("stall_hwdata_n", 64'(hwdata_n), 64'(last_n.d));
            chk("stall_haddr_1", 64'(haddr_1), 64'(32'h8000_0008));
        end
        pipe_push(32'h8000_000C, 32'h44, 1'b0);
        pipe_push(32'h8800_0000, 32'h55, 1'b1);
        htrans = HTRANS_IDLE;

        miss_seq("err", 1'b1);

        bridge_ready = 1'b0;
        #1;
        chk("bp_hreadyout", 64'(hreadyout), 64'(0));
        miss_seq("err_bp", 1'b0);
        bridge_ready = 1'b1;

        htrans = HTRANS_NONSEQ;
        haddr  = 32'h9000_0000;
        rq.push_back('{ERR_EN ? HRESP_ERROR : HRESP_OKAY, ERR_EN ? 1'b0 : 1'b1});
        tick();
        htrans = HTRANS_IDLE;
        #1;
        pop_rsp("midrst_err1");
        hreset = 1'b1;
        tick();
        hreset  = 1'b0;
        exp_cnt = 0;
        chk("midrst_hresp", 64'(hresp), 64'(HRESP_OKAY));
        chk("midrst_hreadyout", 64'(hreadyout), 64'(1));
        chk("midrst_err_cnt", 64'(err_cnt), 64'(0));
        tick();
        chk("midrst_hresp2", 64'(hresp), 64'(HRESP_OKAY));
        chk("midrst_hreadyout2", 64'(hreadyout), 64'(1));

        for (int i = 0; i < 5; i++)
            miss_seq("sat", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
